pc_next_sel: RTL and testbench
==============================

// Module: pc_next_sel
// PURPOSE
//  Parametrised next-PC unit for the RISC-V core. Owns the architectural PC register.
//  Selects the next PC each cycle, in priority order: trap, JALR, JAL, taken branch, sequential.
//  Holds requested redirects across stalls and emits a one-cycle flush to the IF/ID stage.
//  Sits between the execute stage (targets, branch outcome) and the instruction fetch address port.
// PARAMETERS
//  XLEN       32            address/data width
//  RESET_VEC  32'h0000_0000 PC value loaded by reset (XLEN bits)
//  INC        4             sequential increment in bytes
// PORTS
//  clk              in   1     rising-edge clock
//  rst_n            in   1     synchronous reset, active-low
//  inst             in   32    instruction in execute; inst[6:0] is decoded as the opcode
//  br_taken         in   1     branch comparison result for inst
//  br_target        in   XLEN  PC+imm target for a branch or JAL
//  jalr_target      in   XLEN  rs1+imm target for JALR
//  trap_valid       in   1     trap request
//  trap_vec         in   XLEN  trap handler address
//  stall            in   1     hold the PC this cycle
//  pc               out  XLEN  current fetch PC (registered)
//  flush            out  1     registered pulse: a redirect was applied this cycle
//  redirect_pending out  1     a redirect is latched and waiting for stall to deassert
//  addr_misaligned  out  1     registered pulse: the selected target is not 4-byte aligned
// BEHAVIOUR
//  Reset (rst_n=0 at posedge clk): pc=RESET_VEC; flush=0; redirect_pending=0; addr_misaligned=0.
//  Opcode decode: BRANCH 7'b1100011, JAL 7'b1101111, JALR 7'b1100111. Any other opcode is sequential.
//  Request selection (combinational, one winner):
//    trap_valid -> trap_vec
//    else JALR -> {jalr_target[XLEN-1:1],1'b0}
//    else JAL -> br_target
//    else BRANCH && br_taken -> br_target
//    else none.
//  Latency: the PC changes 1 cycle after the request. flush asserts in the same cycle the new pc appears.
//  No stall, no pending redirect:
//    request -> pc<=target, flush<=1.
//    no request -> pc<=pc+INC (wraps modulo 2^XLEN), flush<=0.
//  stall=1:
//    pc holds; flush<=0.
//    A request is latched into pend_tgt, and redirect_pending<=1.
//    While pending, a later trap overwrites the latched target. A later non-trap request is ignored (first wins).
//  Stall release: stall=0 with redirect_pending=1 -> pc<=pend_tgt, flush<=1, redirect_pending<=0.
//    A new non-trap request arriving in that same cycle is dropped, because the flush squashes it.
//    A new trap in that same cycle wins and is applied instead of pend_tgt.
//  Alignment: if the selected target has bit[1]=1:
//    addr_misaligned<=1 for one cycle; no redirect and no pend latch.
//    pc follows the no-request rule (advances, or holds under stall).
//    A trap target is never checked.
//  Simultaneous stall and trap: the trap is latched, never dropped.
//  Reset mid-stall or mid-pending discards the pending redirect.
//  Unknown inputs: the === comparisons treat X or Z opcodes as sequential.
// STRUCTURE
//  Shared package riscv_pkg:
//    localparams OPC_BRANCH, OPC_JAL, OPC_JALR.
//    typedef redir_src_e {SRC_SEQ, SRC_BR, SRC_JAL, SRC_JALR, SRC_TRAP}.
//  Sub-module pc_redirect_arb: combinational priority select.
//    Inputs: inst, br_taken, targets, trap.
//    Outputs: req_valid, req_src, req_tgt, req_misaligned.
//  Top level: PC register, pending register (valid, target, is_trap), flush and misalign flops.
// TESTING
//  1. Reset with RESET_VEC=0x100, then 3 cycles of NOP -> pc=0x100, 0x104, 0x108, 0x10C; flush stays 0.
//  2. pc=0x200, BRANCH with br_taken=1, br_target=0x400 -> next cycle pc=0x400, flush=1 for exactly 1 cycle.
//     Same case with br_taken=0 -> pc=0x204.
//  3. JALR, jalr_target=0x0000_1001 -> pc=0x1000, addr_misaligned=0.
//     JAL, br_target=0x0000_1002 -> addr_misaligned=1 for 1 cycle, pc=pc+4.
//  4. stall=1 for 3 cycles; JAL to 0x800 in cycle 1, BRANCH taken to 0x900 in cycle 2
//     -> pc held, redirect_pending=1; on release pc=0x800, flush=1.
//  5. stall=1 with pending 0x800, then trap_valid to 0x40 -> release gives pc=0x40;
//     trap and JAL in the same cycle -> pc=trap_vec.
//  6. rst_n=0 while redirect_pending=1 -> pc=RESET_VEC, redirect_pending=0, and no flush after reset.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: control-flow opcodes and redirect source encoding.
package riscv_pkg;

  // Major opcodes (inst[6:0]) that can change control flow.
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  // Which source won the next-PC selection this cycle.
  typedef enum logic [2:0] {
    SRC_SEQ  = 3'd0,
    SRC_BR   = 3'd1,
    SRC_JAL  = 3'd2,
    SRC_JALR = 3'd3,
    SRC_TRAP = 3'd4
  } redir_src_e;

  // Bit 1 set means the target is not on a 4-byte boundary.
  function automatic logic tgt_misaligned(input logic [1:0] low_bits);
    return low_bits[1];
  endfunction

endpackage

// File: rtl/pc_redirect_arb.sv
// Combinational priority select of the redirect request:
// trap > JALR > JAL > taken branch > sequential.
module pc_redirect_arb
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_target,
  input  logic [XLEN-1:0] jalr_target,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_vec,
  output logic            req_valid,
  output redir_src_e      req_src,
  output logic [XLEN-1:0] req_tgt,
  output logic            req_misaligned
);

  logic [6:0] opcode;
  logic       is_branch;
  logic       is_jal;
  logic       is_jalr;

  assign opcode = inst[6:0];

  // Case-equality decode: an X or Z opcode matches nothing and falls to sequential.
  always_comb begin
    is_branch = (opcode === OPC_BRANCH);
    is_jal    = (opcode === OPC_JAL);
    is_jalr   = (opcode === OPC_JALR);
  end

  // Priority selection; trap targets are never alignment-checked.
  always_comb begin
    req_valid      = 1'b0;
    req_src        = SRC_SEQ;
    req_tgt        = '0;
    req_misaligned = 1'b0;
    if (trap_valid) begin
      req_valid = 1'b1;
      req_src   = SRC_TRAP;
      req_tgt   = trap_vec;
    end else if (is_jalr) begin
      req_valid      = 1'b1;
      req_src        = SRC_JALR;
      req_tgt        = {jalr_target[XLEN-1:1], 1'b0};
      req_misaligned = tgt_misaligned(req_tgt[1:0]);
    end else if (is_jal) begin
      req_valid      = 1'b1;
      req_src        = SRC_JAL;
      req_tgt        = br_target;
      req_misaligned = tgt_misaligned(req_tgt[1:0]);
    end else if (is_branch && (br_taken === 1'b1)) begin
      req_valid      = 1'b1;
      req_src        = SRC_BR;
      req_tgt        = br_target;
      req_misaligned = tgt_misaligned(req_tgt[1:0]);
    end
  end

endmodule

// File: rtl/pc_next_sel.sv
// Next-PC unit: owns the architectural PC, holds redirects across stalls,
// and emits a one-cycle flush when a redirect lands on the fetch PC.
// Handshake: stall is a hold request; a redirect seen while stalled is
// parked (redirect_pending=1) and applied on the first cycle stall is low.
module pc_next_sel
  import riscv_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter int              INC       = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [31:0]     inst,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_target,
  input  logic [XLEN-1:0] jalr_target,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_vec,
  input  logic            stall,
  output logic [XLEN-1:0] pc,
  output logic            flush,
  output logic            redirect_pending,
  output logic            addr_misaligned
);

  logic            req_valid;
  redir_src_e      req_src;
  logic [XLEN-1:0] req_tgt;
  logic            req_misaligned;
  logic            req_ok;
  logic            req_is_trap;

  logic [XLEN-1:0] pc_q, pc_d;
  logic            flush_q, flush_d;
  logic            mis_q, mis_d;
  logic            pend_valid_q, pend_valid_d;
  logic [XLEN-1:0] pend_tgt_q, pend_tgt_d;
  logic            pend_is_trap_q, pend_is_trap_d;

  pc_redirect_arb #(.XLEN(XLEN)) u_arb (
    .inst           (inst),
    .br_taken       (br_taken),
    .br_target      (br_target),
    .jalr_target    (jalr_target),
    .trap_valid     (trap_valid),
    .trap_vec       (trap_vec),
    .req_valid      (req_valid),
    .req_src        (req_src),
    .req_tgt        (req_tgt),
    .req_misaligned (req_misaligned)
  );

  // A misaligned target is reported but never taken or parked.
  assign req_ok      = req_valid && !req_misaligned;
  assign req_is_trap = (req_src == SRC_TRAP);

  // Next-state for PC, pending redirect and the two status pulses.
  always_comb begin
    pc_d           = pc_q;
    flush_d        = 1'b0;
    mis_d          = 1'b0;
    pend_valid_d   = pend_valid_q;
    pend_tgt_d     = pend_tgt_q;
    pend_is_trap_d = pend_is_trap_q;
    if (stall) begin
      // PC frozen; park the first request, but a trap always replaces
      // a parked non-trap or older trap target.
      mis_d = req_misaligned;
      if (req_ok && (!pend_valid_q || req_is_trap)) begin
        pend_valid_d   = 1'b1;
        pend_tgt_d     = req_tgt;
        pend_is_trap_d = req_is_trap;
      end
    end else if (pend_valid_q) begin
      // Release: the flush squashes any new non-trap request; a new trap wins.
      pc_d           = req_is_trap ? req_tgt : pend_tgt_q;
      flush_d        = 1'b1;
      pend_valid_d   = 1'b0;
      pend_is_trap_d = 1'b0;
    end else if (req_ok) begin
      pc_d    = req_tgt;
      flush_d = 1'b1;
    end else begin
      pc_d  = pc_q + XLEN'(INC);
      mis_d = req_misaligned;
    end
  end

  // State registers with synchronous active-low reset; reset drops any parked redirect.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q           <= RESET_VEC;
      flush_q        <= 1'b0;
      mis_q          <= 1'b0;
      pend_valid_q   <= 1'b0;
      pend_tgt_q     <= '0;
      pend_is_trap_q <= 1'b0;
    end else begin
      pc_q           <= pc_d;
      flush_q        <= flush_d;
      mis_q          <= mis_d;
      pend_valid_q   <= pend_valid_d;
      pend_tgt_q     <= pend_tgt_d;
      pend_is_trap_q <= pend_is_trap_d;
    end
  end

  assign pc               = pc_q;
  assign flush            = flush_q;
  assign redirect_pending = pend_valid_q;
  assign addr_misaligned  = mis_q;

endmodule

// File: tb/tb_pc_next_sel.sv
// Directed bench for pc_next_sel with RESET_VEC=0x100, expected-result queue.
module tb_pc_next_sel;

  localparam int          XLEN = 32;
  localparam logic [31:0] RVEC = 32'h0000_0100;

  localparam logic [31:0] I_NOP  = 32'h0000_0013;
  localparam logic [31:0] I_BR   = 32'h0000_0063;
  localparam logic [31:0] I_JAL  = 32'h0000_006F;
  localparam logic [31:0] I_JALR = 32'h0000_0067;

  // clock / reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic [31:0]     inst;
  logic            br_taken;
  logic [XLEN-1:0] br_target;
  logic [XLEN-1:0] jalr_target;
  logic            trap_valid;
  logic [XLEN-1:0] trap_vec;
  logic            stall;
  logic [XLEN-1:0] pc;
  logic            flush;
  logic            redirect_pending;
  logic            addr_misaligned;

  pc_next_sel #(.XLEN(XLEN), .RESET_VEC(RVEC), .INC(4)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .inst             (inst),
    .br_taken         (br_taken),
    .br_target        (br_target),
    .jalr_target      (jalr_target),
    .trap_valid       (trap_valid),
    .trap_vec         (trap_vec),
    .stall            (stall),
    .pc               (pc),
    .flush            (flush),
    .redirect_pending (redirect_pending),
    .addr_misaligned  (addr_misaligned)
  );

  // scoreboard: {pc, flush, pending, misaligned}
  logic [XLEN+2:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // driver: apply one cycle of inputs (random don't-care targets where unused)
  task automatic drive(input logic rst, input logic stl, input logic [31:0] in,
                       input logic tk, input logic [31:0] bt, input logic [31:0] jt,
                       input logic tv, input logic [31:0] tvec);
    rst_n = rst; stall = stl; inst = in; br_taken = tk;
    br_target = bt; jalr_target = jt; trap_valid = tv; trap_vec = tvec;
  endtask

  task automatic nop(input logic stl);
    drive(1'b1, stl, I_NOP, 1'($urandom_range(0, 1)), {$urandom_range(0, 255), 2'b00} << 4,
          32'h0, 1'b0, 32'h0);
  endtask

  // push the expected post-edge state, advance one cycle, pop and compare
  task automatic step(input string tag, input logic [31:0] e_pc, input logic e_fl,
                      input logic e_pend, input logic e_mis);
    logic [XLEN+2:0] e;
    exp_q.push_back({e_pc, e_fl, e_pend, e_mis});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_eq({tag, ".pc"},    pc,                      e[XLEN+2:3]);
    check_eq({tag, ".flush"}, {31'b0, flush},          {31'b0, e[2]});
    check_eq({tag, ".pend"},  {31'b0, redirect_pending}, {31'b0, e[1]});
    check_eq({tag, ".mis"},   {31'b0, addr_misaligned},  {31'b0, e[0]});
  endtask

  initial begin
    nop(1'b0);
    @(posedge clk); #1;
    // 1. reset and sequential fetch
    drive(1'b0, 1'b0, I_NOP, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    step("rst", RVEC, 0, 0, 0);
    nop(1'b0); step("seq1", 32'h104, 0, 0, 0);
    nop(1'b0); step("seq2", 32'h108, 0, 0, 0);
    nop(1'b0); step("seq3", 32'h10C, 0, 0, 0);
    // 2. taken / not-taken branch from 0x200
    drive(1, 0, I_JAL, 0, 32'h200, 0, 0, 0); step("jal200", 32'h200, 1, 0, 0);
    drive(1, 0, I_BR, 1, 32'h400, 0, 0, 0);  step("br_tk", 32'h400, 1, 0, 0);
    nop(1'b0);                               step("br_tk_after", 32'h404, 0, 0, 0);
    drive(1, 0, I_JAL, 0, 32'h200, 0, 0, 0); step("jal200b", 32'h200, 1, 0, 0);
    drive(1, 0, I_BR, 0, 32'h400, 0, 0, 0);  step("br_nt", 32'h204, 0, 0, 0);
    // 3. JALR clears bit 0; JAL to bit1-set target is flagged and not taken
    drive(1, 0, I_JALR, 0, 0, 32'h1001, 0, 0); step("jalr", 32'h1000, 1, 0, 0);
    drive(1, 0, I_JAL, 0, 32'h1002, 0, 0, 0);  step("jal_mis", 32'h1004, 0, 0, 1);
    nop(1'b0);                                 step("mis_pulse", 32'h1008, 0, 0, 0);
    // unknown opcode behaves as sequential
    drive(1, 0, 32'hxxxx_xxxx, 1, 32'h500, 32'h500, 0, 0); step("x_opc", 32'h100C, 0, 0, 0);
    // 4. stall: first request wins, applied on release
    drive(1, 1, I_JAL, 0, 32'h800, 0, 0, 0); step("st1", 32'h100C, 0, 1, 0);
    drive(1, 1, I_BR, 1, 32'h900, 0, 0, 0);  step("st2", 32'h100C, 0, 1, 0);
    nop(1'b1);                               step("st3", 32'h100C, 0, 1, 0);
    nop(1'b0);                               step("rel", 32'h800, 1, 0, 0);
    nop(1'b0);                               step("rel_after", 32'h804, 0, 0, 0);
    // 5. trap overwrites parked target; trap beats JAL
    drive(1, 1, I_JAL, 0, 32'h800, 0, 0, 0); step("st_jal", 32'h804, 0, 1, 0);
    drive(1, 1, I_NOP, 0, 0, 0, 1, 32'h40);  step("st_trap", 32'h804, 0, 1, 0);
    nop(1'b0);                               step("rel_trap", 32'h40, 1, 0, 0);
    drive(1, 0, I_JAL, 0, 32'hA00, 0, 1, 32'h80); step("trap_jal", 32'h80, 1, 0, 0);
    // new trap at release wins over parked target
    drive(1, 1, I_JAL, 0, 32'h800, 0, 0, 0);  step("st_jal2", 32'h80, 0, 1, 0);
    drive(1, 0, I_NOP, 0, 0, 0, 1, 32'hC0);   step("rel_newtrap", 32'hC0, 1, 0, 0);
    // new non-trap at release is dropped
    drive(1, 1, I_JAL, 0, 32'h800, 0, 0, 0);  step("st_jal3", 32'hC0, 0, 1, 0);
    drive(1, 0, I_JAL, 0, 32'h300, 0, 0, 0);  step("rel_drop", 32'h800, 1, 0, 0);
    nop(1'b0);                                step("drop_after", 32'h804, 0, 0, 0);
    // misaligned under stall: flagged, not parked; trap target never checked
    drive(1, 1, I_BR, 1, 32'h702, 0, 0, 0);   step("st_mis", 32'h804, 0, 0, 1);
    drive(1, 0, I_NOP, 0, 0, 0, 1, 32'hFFFF_FFFE); step("trap_unchk", 32'hFFFF_FFFE, 1, 0, 0);
    drive(1, 0, I_NOP, 0, 0, 0, 1, 32'hFFFF_FFFC); step("trap_top", 32'hFFFF_FFFC, 1, 0, 0);
    nop(1'b0);                                step("wrap", 32'h0, 0, 0, 0);
    // 6. reset while pending discards the redirect
    drive(1, 1, I_JAL, 0, 32'h600, 0, 0, 0);  step("st_rst", 32'h0, 0, 1, 0);
    drive(0, 1, I_JAL, 0, 32'h600, 0, 0, 0);  step("rst_pend", RVEC, 0, 0, 0);
    nop(1'b0);                                step("rst_after", 32'h104, 0, 0, 0);
    nop(1'b0);                                step("rst_after2", 32'h108, 0, 0, 0);

    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain: got %0d left expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
